// File: rtl/interboard_tx_arbiter_pkg.sv
// Shared state encodings, field widths and message record for the interboard transmit arbiter.
package interboard_tx_arbiter_pkg;

    localparam int unsigned BX_W   = 5;
    localparam int unsigned BY_W   = 3;
    localparam int unsigned MT_W   = 4;
    localparam int unsigned CARD_W = 6;
    localparam int unsigned SL_W   = 3;
    localparam int unsigned IDX_W  = 3;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_BUSY  = 2'd1,
        WAIT_READY = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic              move_dir;
        logic [BX_W-1:0]   block_x;
        logic [BY_W-1:0]   block_y;
        logic [MT_W-1:0]   msg_type;
        logic [CARD_W-1:0] card;
        logic [SL_W-1:0]   sel_len;
    } ctrl_msg_t;

endpackage

// File: rtl/interboard_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of i_pending at or after i_ptr, wrapping.
module rr_pick
    import interboard_tx_arbiter_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]     i_pending,
    input  logic [IDX_W-1:0] i_ptr,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_idx
);

    logic [N-1:0]     w_rot;
    logic [IDX_W-1:0] w_off;
    logic [IDX_W:0]   w_sum;

    always_comb begin
        // Rotate so the pointer position lands at bit 0; lowest set bit is the winner.
        w_rot   = N'({i_pending, i_pending} >> i_ptr);
        o_valid = |w_rot;
        w_off   = '0;
        for (int unsigned j = 0; j < N; j++) begin
            if (w_rot[N-1-j]) begin
                w_off = IDX_W'(N-1-j);
            end
        end
        w_sum = {1'b0, i_ptr} + {1'b0, w_off};
        if (w_sum >= (IDX_W+1)'(N)) begin
            w_sum = w_sum - (IDX_W+1)'(N);
        end
        o_idx = w_sum[IDX_W-1:0];
    end

endmodule

// File: rtl/interboard_tx_arbiter.sv
// Shares the interboard transmit channel between game-control handlers: per-source
// request slots, round-robin grant, one ctrl_en pulse per accepted message.
module interboard_tx_arbiter
    import interboard_tx_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned ACK_TIMEOUT = 1023
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        interboard_rst,
    input  logic                        inter_ready,
    input  logic [NUM_REQ-1:0]          req_en,
    input  logic [NUM_REQ-1:0]          req_move_dir,
    input  logic [BX_W*NUM_REQ-1:0]     req_block_x,
    input  logic [BY_W*NUM_REQ-1:0]     req_block_y,
    input  logic [MT_W*NUM_REQ-1:0]     req_msg_type,
    input  logic [CARD_W*NUM_REQ-1:0]   req_card,
    input  logic [SL_W*NUM_REQ-1:0]     req_sel_len,
    output logic                        ctrl_en,
    output logic                        ctrl_move_dir,
    output logic [BX_W-1:0]             ctrl_block_x,
    output logic [BY_W-1:0]             ctrl_block_y,
    output logic [MT_W-1:0]             ctrl_msg_type,
    output logic [CARD_W-1:0]           ctrl_card,
    output logic [SL_W-1:0]             ctrl_sel_len,
    output logic [NUM_REQ-1:0]          pending,
    output logic [IDX_W-1:0]            grant_idx,
    output logic                        overflow
);

    localparam int unsigned     CNT_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    logic             w_rst;
    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic [NUM_REQ-1:0] r_pending;
    ctrl_msg_t        r_slot [NUM_REQ];
    ctrl_msg_t        w_req_msg [NUM_REQ];
    logic             r_overflow;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] r_grant_idx;
    logic             r_ctrl_en;
    ctrl_msg_t        r_ctrl;
    logic [CNT_W-1:0] r_cnt;
    logic             w_pick_valid;
    logic [IDX_W-1:0] w_pick_idx;
    logic             w_grant;
    ctrl_msg_t        w_sel;
    logic [NUM_REQ-1:0] w_grant_oh;

    assign w_rst = rst | interboard_rst;

    rr_pick #(.N(NUM_REQ)) u_rr_pick (
        .i_pending (r_pending),
        .i_ptr     (r_ptr),
        .o_valid   (w_pick_valid),
        .o_idx     (w_pick_idx)
    );

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_req_msg[i].move_dir = req_move_dir[i];
            w_req_msg[i].block_x  = req_block_x[BX_W*i +: BX_W];
            w_req_msg[i].block_y  = req_block_y[BY_W*i +: BY_W];
            w_req_msg[i].msg_type = req_msg_type[MT_W*i +: MT_W];
            w_req_msg[i].card     = req_card[CARD_W*i +: CARD_W];
            w_req_msg[i].sel_len  = req_sel_len[SL_W*i +: SL_W];
        end
    end

    always_comb begin
        w_grant    = (r_state == IDLE) && inter_ready && w_pick_valid;
        w_sel      = '0;
        w_grant_oh = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_pick_idx == IDX_W'(i)) begin
                w_sel         = r_slot[i];
                w_grant_oh[i] = w_grant;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant) w_state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!inter_ready)           w_state_nxt = WAIT_READY;
                else if (r_cnt == CNT_LAST) w_state_nxt = IDLE;
            end
            WAIT_READY: begin
                if (inter_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_rst) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (w_rst || r_state != WAIT_BUSY) r_cnt <= '0;
        else                               r_cnt <= r_cnt + 1'b1;
    end

    // A slot being granted this cycle is free to take a new request in the same cycle.
    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_pending  <= '0;
            r_overflow <= 1'b0;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                r_slot[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (req_en[i] && (!r_pending[i] || w_grant_oh[i])) begin
                    r_slot[i]    <= w_req_msg[i];
                    r_pending[i] <= 1'b1;
                end else if (w_grant_oh[i]) begin
                    r_pending[i] <= 1'b0;
                end
                if (req_en[i] && r_pending[i] && !w_grant_oh[i]) begin
                    r_overflow <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_ctrl_en   <= 1'b0;
            r_ctrl      <= '0;
            r_grant_idx <= '0;
            r_ptr       <= '0;
        end else begin
            r_ctrl_en <= w_grant;
            if (w_grant) begin
                r_ctrl      <= w_sel;
                r_grant_idx <= w_pick_idx;
                r_ptr       <= (w_pick_idx == IDX_W'(NUM_REQ-1)) ? '0 : w_pick_idx + 1'b1;
            end
        end
    end

    assign ctrl_en       = r_ctrl_en;
    assign ctrl_move_dir = r_ctrl.move_dir;
    assign ctrl_block_x  = r_ctrl.block_x;
    assign ctrl_block_y  = r_ctrl.block_y;
    assign ctrl_msg_type = r_ctrl.msg_type;
    assign ctrl_card     = r_ctrl.card;
    assign ctrl_sel_len  = r_ctrl.sel_len;
    assign pending       = r_pending;
    assign grant_idx     = r_grant_idx;
    assign overflow      = r_overflow;

endmodule

// File: tb/tb_interboard_tx_arbiter.sv
// Directed bench for interboard_tx_arbiter (NUM_REQ=4, ACK_TIMEOUT=8).
module tb_interboard_tx_arbiter;
    import interboard_tx_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        interboard_rst;
    logic        inter_ready;
    logic [3:0]  req_en;
    logic [3:0]  req_move_dir;
    logic [19:0] req_block_x;
    logic [11:0] req_block_y;
    logic [15:0] req_msg_type;
    logic [23:0] req_card;
    logic [11:0] req_sel_len;
    logic        ctrl_en;
    logic        ctrl_move_dir;
    logic [4:0]  ctrl_block_x;
    logic [2:0]  ctrl_block_y;
    logic [3:0]  ctrl_msg_type;
    logic [5:0]  ctrl_card;
    logic [2:0]  ctrl_sel_len;
    logic [3:0]  pending;
    logic [2:0]  grant_idx;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    logic tx_auto   = 1'b0;
    logic man_ready = 1'b0;
    logic tx_ready  = 1'b1;
    int   busy_cnt  = 0;
    logic [12:0] log_q [$];

    assign inter_ready = tx_auto ? tx_ready : man_ready;

    interboard_tx_arbiter #(.NUM_REQ(4), .ACK_TIMEOUT(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .interboard_rst (interboard_rst),
        .inter_ready    (inter_ready),
        .req_en         (req_en),
        .req_move_dir   (req_move_dir),
        .req_block_x    (req_block_x),
        .req_block_y    (req_block_y),
        .req_msg_type   (req_msg_type),
        .req_card       (req_card),
        .req_sel_len    (req_sel_len),
        .ctrl_en        (ctrl_en),
        .ctrl_move_dir  (ctrl_move_dir),
        .ctrl_block_x   (ctrl_block_x),
        .ctrl_block_y   (ctrl_block_y),
        .ctrl_msg_type  (ctrl_msg_type),
        .ctrl_card      (ctrl_card),
        .ctrl_sel_len   (ctrl_sel_len),
        .pending        (pending),
        .grant_idx      (grant_idx),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    // Issue log plus a transmitter that goes busy for 5 cycles per message.
    always @(negedge clk) begin
        if (ctrl_en === 1'b1) begin
            log_q.push_back({grant_idx, ctrl_msg_type, ctrl_card});
            busy_cnt = 5;
        end else if (busy_cnt > 0) begin
            busy_cnt = busy_cnt - 1;
        end
        tx_ready = (busy_cnt == 0);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [12:0] ent(input int k);
        if (k < log_q.size()) return log_q[k];
        return 'x;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_src(input int i, input logic [3:0] mt, input logic [5:0] cd);
        req_msg_type[4*i +: 4] = mt;
        req_card[6*i +: 6]     = cd;
        req_block_x[5*i +: 5]  = 5'(i + 3);
        req_block_y[3*i +: 3]  = 3'(i);
        req_sel_len[3*i +: 3]  = 3'(i + 1);
        req_move_dir[i]        = (i % 2 == 0);
    endtask

    task automatic pulse(input logic [3:0] m);
        req_en = m;
        @(negedge clk);
        req_en = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; interboard_rst = 1'b0; req_en = '0;
        req_move_dir = '0; req_block_x = '0; req_block_y = '0;
        req_msg_type = '0; req_card = '0; req_sel_len = '0;
        tick(3);
        rst = 1'b0;

        chk("rst_ctrl_en", ctrl_en, 0);
        chk("rst_pending", pending, 0);
        chk("rst_grant_idx", grant_idx, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_card", ctrl_card, 0);
        chk("rst_state", 32'(dut.r_state), 32'(IDLE));

        // Single request: issued two cycles after req_en.
        man_ready = 1'b1;
        set_src(0, 4'h3, 6'd17);
        pulse(4'b0001);
        chk("t1_pending_set", pending, 4'b0001);
        chk("t1_no_early_en", ctrl_en, 0);
        tick(1);
        chk("t1_ctrl_en", ctrl_en, 1);
        chk("t1_msg_type", ctrl_msg_type, 4'h3);
        chk("t1_card", ctrl_card, 6'd17);
        chk("t1_block_x", ctrl_block_x, 5'd3);
        chk("t1_move_dir", ctrl_move_dir, 1);
        chk("t1_sel_len", ctrl_sel_len, 3'd1);
        chk("t1_grant_idx", grant_idx, 0);
        chk("t1_pending_clr", pending, 0);
        chk("t1_state", 32'(dut.r_state), 32'(WAIT_BUSY));
        tick(1);
        chk("t1_en_one_cycle", ctrl_en, 0);
        man_ready = 1'b0; tick(2);
        man_ready = 1'b1; tick(2);
        chk("t1_issue_count", log_q.size(), 1);

        // Round-robin fairness from pointer 0.
        do_reset();
        log_q.delete();
        tx_auto = 1'b1;
        set_src(0, 4'd1, 6'd10);
        set_src(1, 4'd2, 6'd11);
        set_src(3, 4'd4, 6'd13);
        pulse(4'b1011);
        tick(40);
        tx_auto = 1'b0; man_ready = 1'b1;
        chk("t2_issue_count", log_q.size(), 3);
        chk("t2_issue0", ent(0), {3'd0, 4'd1, 6'd10});
        chk("t2_issue1", ent(1), {3'd1, 4'd2, 6'd11});
        chk("t2_issue2", ent(2), {3'd3, 4'd4, 6'd13});
        chk("t2_pending", pending, 0);

        // Overflow: second request to a pending slot is dropped.
        log_q.delete();
        man_ready = 1'b0;
        set_src(2, 4'd5, 6'd21);
        pulse(4'b0100);
        chk("t3_ovf_clear", overflow, 0);
        chk("t3_pending", pending, 4'b0100);
        tick(2);
        set_src(2, 4'd6, 6'd22);
        pulse(4'b0100);
        chk("t3_ovf_set", overflow, 1);
        chk("t3_pending_kept", pending, 4'b0100);
        man_ready = 1'b1;
        tick(1);
        chk("t3_ctrl_en", ctrl_en, 1);
        chk("t3_card_first", ctrl_card, 6'd21);
        chk("t3_grant_idx", grant_idx, 3'd2);
        man_ready = 1'b0; tick(2);
        man_ready = 1'b1; tick(6);
        chk("t3_issue_count", log_q.size(), 1);
        chk("t3_issue0", ent(0), {3'd2, 4'd5, 6'd21});
        chk("t3_ovf_sticky", overflow, 1);
        chk("t3_pending_end", pending, 0);

        // Same-cycle regrant of slot 1.
        do_reset();
        log_q.delete();
        man_ready = 1'b0;
        set_src(1, 4'd7, 6'd30);
        pulse(4'b0010);
        chk("t4_pending", pending, 4'b0010);
        set_src(1, 4'd8, 6'd40);
        req_en = 4'b0010;
        man_ready = 1'b1;
        tick(1);
        req_en = '0;
        chk("t4_first_en", ctrl_en, 1);
        chk("t4_first_card", ctrl_card, 6'd30);
        chk("t4_grant_idx", grant_idx, 3'd1);
        chk("t4_pending_reload", pending, 4'b0010);
        chk("t4_no_overflow", overflow, 0);
        man_ready = 1'b0; tick(1);
        man_ready = 1'b1; tick(1);
        chk("t4_no_en_on_return", ctrl_en, 0);
        tick(1);
        chk("t4_second_en", ctrl_en, 1);
        chk("t4_second_card", ctrl_card, 6'd40);
        chk("t4_second_msg", ctrl_msg_type, 4'd8);
        chk("t4_pending_end", pending, 0);
        tick(12);
        chk("t4_issue_count", log_q.size(), 2);
        chk("t4_issue1", ent(1), {3'd1, 4'd8, 6'd40});

        // Timeout: inter_ready never drops, WAIT_BUSY lasts 8 cycles.
        log_q.delete();
        set_src(0, 4'd9, 6'd5);
        pulse(4'b0001);
        tick(1);
        chk("t5_first_en", ctrl_en, 1);
        chk("t5_first_card", ctrl_card, 6'd5);
        set_src(3, 4'd10, 6'd7);
        pulse(4'b1000);
        tick(6);
        chk("t5_still_busy", 32'(dut.r_state), 32'(WAIT_BUSY));
        chk("t5_no_en_busy", ctrl_en, 0);
        tick(1);
        chk("t5_back_idle", 32'(dut.r_state), 32'(IDLE));
        chk("t5_no_en_idle", ctrl_en, 0);
        chk("t5_queued", pending, 4'b1000);
        tick(1);
        chk("t5_second_en", ctrl_en, 1);
        chk("t5_second_card", ctrl_card, 6'd7);
        chk("t5_second_idx", grant_idx, 3'd3);

        // Peer reset while in WAIT_BUSY with slots 1 and 2 pending.
        set_src(1, 4'd11, 6'd33);
        set_src(2, 4'd12, 6'd34);
        req_en = 4'b0110;
        tick(1);
        req_en = 4'b0010;
        tick(1);
        req_en = '0;
        chk("t6_pending_pre", pending, 4'b0110);
        chk("t6_ovf_pre", overflow, 1);
        chk("t6_state_pre", 32'(dut.r_state), 32'(WAIT_BUSY));
        interboard_rst = 1'b1;
        tick(1);
        interboard_rst = 1'b0;
        chk("t6_pending", pending, 0);
        chk("t6_overflow", overflow, 0);
        chk("t6_state", 32'(dut.r_state), 32'(IDLE));
        chk("t6_ctrl_en", ctrl_en, 0);
        chk("t6_card", ctrl_card, 0);
        chk("t6_grant_idx", grant_idx, 0);
        tick(6);
        chk("t6_no_issue_after", log_q.size(), 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/interboard_tx_arbiter.md
Name: interboard_tx_arbiter

Overview:
- Shares the single interboard transmit channel between the game-control message sources: handle_advance_state, move, draw and similar handlers.
- Each source raises a one-cycle ctrl_en pulse with its message fields.
- The arbiter latches each pulse into a per-source slot, grants the channel round-robin when the transmitter reports ready, and issues exactly one ctrl_en pulse per accepted message.
- It sits between the GameControl handlers and the interboard transmitter.

Parameters:
- NUM_REQ, 4, number of requesting handlers (2..8).
- ACK_TIMEOUT, 1023, max cycles to wait for inter_ready to drop after an issue before returning to IDLE.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- interboard_rst  in  1  synchronous active-high reset from the peer board; same effect as rst
- inter_ready  in  1  transmitter idle/ready
- req_en  in  NUM_REQ  per-source one-cycle request pulse
- req_move_dir  in  NUM_REQ  per-source move_dir
- req_block_x  in  5*NUM_REQ  per-source block_x; source i occupies [5i+4:5i]
- req_block_y  in  3*NUM_REQ  per-source block_y
- req_msg_type  in  4*NUM_REQ  per-source msg_type
- req_card  in  6*NUM_REQ  per-source card
- req_sel_len  in  3*NUM_REQ  per-source sel_len
- ctrl_en  out  1  one-cycle issue pulse to the transmitter
- ctrl_move_dir  out  1  issued move_dir
- ctrl_block_x  out  5  issued block_x
- ctrl_block_y  out  3  issued block_y
- ctrl_msg_type  out  4  issued msg_type
- ctrl_card  out  6  issued card
- ctrl_sel_len  out  3  issued sel_len
- pending  out  NUM_REQ  slot i holds an unsent message
- grant_idx  out  3  index of the last issued source
- overflow  out  1  sticky; a request was dropped

Behaviour:
- Reset: rst or interboard_rst clears everything; outputs are 0, the round-robin pointer is 0 and the FSM goes to IDLE.
- Slot capture:
  - On req_en[i] with pending[i]=0, latch that source's fields and set pending[i] the next cycle.
  - On req_en[i] with pending[i]=1, drop the new request, keep the old fields and set overflow.
  - If the slot is being granted in the same cycle, the new request is accepted (slot cleared and reloaded); pending[i] stays 1.
- FSM IDLE: if inter_ready=1 and any pending bit is set, choose the first pending index at or after the round-robin pointer, wrapping modulo NUM_REQ. Then:
  - register its fields onto the ctrl_* outputs;
  - pulse ctrl_en for exactly 1 cycle;
  - clear that pending bit;
  - set grant_idx and set the pointer to grant_idx+1 (wrapping).
  - Go to WAIT_BUSY.
- Latency: a request arriving with the FSM in IDLE and inter_ready=1 is issued 2 cycles after its req_en (capture cycle, then grant cycle).
- FSM WAIT_BUSY:
  - Wait for inter_ready=0, then go to WAIT_READY.
  - A cycle counter starts at 0. If it reaches ACK_TIMEOUT while inter_ready is still 1, return to IDLE (message treated as sent).
- FSM WAIT_READY: on inter_ready=1, go to IDLE. No new grant is made in this same cycle; the next grant is made from IDLE the following cycle.
- ctrl_* data outputs hold the last issued values between pulses. ctrl_en is 0 outside the grant cycle.
- No message is ever issued twice, and ctrl_en is never asserted unless the FSM is in IDLE with inter_ready=1.
- overflow clears only on reset.
- grant_idx is zero-extended to 3 bits.

Decomposition:
- Shared constants go in game_macro.v: FSM state encodings (IDLE/WAIT_BUSY/WAIT_READY) and the field widths (5/3/4/6/3).
- Message type codes stay in message_macro.v.
- One natural sub-module: rr_pick.
  - Combinational round-robin priority picker.
  - Inputs: pending vector, pointer. Outputs: valid, index.
  - Instantiated once.

Test Plan:
- Single request: req_en[0] with msg_type=4'h3, card=6'd17 while inter_ready=1 → ctrl_en pulses 2 cycles later with msg_type 3, card 17; pending[0] returns to 0; FSM goes to WAIT_BUSY.
- Round-robin fairness: req_en = 4'b1011 in one cycle, with the transmitter model dropping inter_ready for 5 cycles per message → issue order 0, 1, 3; grant_idx sequence 0, 1, 3.
- Overflow: req_en[2] twice, 3 cycles apart, while inter_ready=0 → the first payload is issued, the second is dropped, overflow=1; only one ctrl_en for source 2.
- Same-cycle regrant: source 1 pending and being granted while req_en[1] fires with card=6'd40 → two issues total, the second carrying card 40.
- Timeout: inter_ready held at 1 after an issue, with ACK_TIMEOUT=8 → FSM returns to IDLE after 8 cycles; a queued request is issued next.
- Reset mid-operation: interboard_rst for 1 cycle while in WAIT_BUSY with pending=4'b0110 → pending=0, overflow=0, FSM in IDLE, no ctrl_en after reset.
